// File: rtl/sec_wb_dnsz.sv
// Wishbone pipelined bus-width downsizer: one wide request becomes one narrow beat
// per active 32-bit lane, and the narrow read data is merged into one wide response.
module sec_wb_dnsz #(
    parameter int unsigned WIDE_AW   = 26,
    parameter int unsigned WIDE_DW   = 128,
    parameter int unsigned NARROW_DW = 32,
    localparam int unsigned LGR      = $clog2(WIDE_DW / NARROW_DW)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     s_cyc_i,
    input  logic                     s_stb_i,
    input  logic                     s_we_i,
    input  logic [WIDE_AW-1:0]       s_addr_i,
    input  logic [WIDE_DW-1:0]       s_wdata_i,
    input  logic [WIDE_DW/8-1:0]     s_sel_i,
    output logic                     s_stall_o,
    output logic                     s_ack_o,
    output logic                     s_err_o,
    output logic [WIDE_DW-1:0]       s_rdata_o,
    output logic                     m_cyc_o,
    output logic                     m_stb_o,
    output logic                     m_we_o,
    output logic [WIDE_AW+LGR-1:0]   m_addr_o,
    output logic [NARROW_DW-1:0]     m_wdata_o,
    output logic [NARROW_DW/8-1:0]   m_sel_o,
    input  logic                     m_stall_i,
    input  logic                     m_ack_i,
    input  logic                     m_err_i,
    input  logic [NARROW_DW-1:0]     m_rdata_i
);

    localparam int unsigned RATIO = WIDE_DW / NARROW_DW;
    localparam int unsigned NSW   = NARROW_DW / 8;
    localparam int unsigned WSW   = WIDE_DW / 8;
    localparam int unsigned NAW   = WIDE_AW + LGR;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Lowest set lane of a lane mask (lane 0 when the mask is empty).
    function automatic logic [LGR-1:0] low_lane(input logic [RATIO-1:0] m);
        low_lane = '0;
        for (int i = int'(RATIO) - 1; i >= 0; i--) begin
            if (m[i]) low_lane = LGR'(i);
        end
    endfunction

    function automatic logic [RATIO-1:0] onehot(input logic [LGR-1:0] l);
        onehot = RATIO'(1) << l;
    endfunction

    state_e               state_q, state_d;
    logic [WIDE_AW-1:0]   addr_q, addr_d;
    logic [WIDE_DW-1:0]   wdata_q, wdata_d;
    logic [WSW-1:0]       sel_q, sel_d;
    logic                 we_q, we_d;
    logic [RATIO-1:0]     issue_q, issue_d;
    logic [RATIO-1:0]     ret_q, ret_d;
    logic [WIDE_DW-1:0]   rbuf_q, rbuf_d;

    logic                 s_stall_q, s_stall_d;
    logic                 s_ack_q, s_ack_d;
    logic                 s_err_q, s_err_d;
    logic [WIDE_DW-1:0]   s_rdata_q, s_rdata_d;
    logic                 m_cyc_q, m_cyc_d;
    logic                 m_stb_q, m_stb_d;
    logic                 m_we_q, m_we_d;
    logic [NAW-1:0]       m_addr_q, m_addr_d;
    logic [NARROW_DW-1:0] m_wdata_q, m_wdata_d;
    logic [NSW-1:0]       m_sel_q, m_sel_d;

    logic [RATIO-1:0]     lanes_in;
    logic                 stb_acc;
    logic                 ack_v;
    logic                 err_v;
    logic [LGR-1:0]       ret_lane;
    logic [RATIO-1:0]     issue_nxt;
    logic [RATIO-1:0]     ret_nxt;
    logic [WIDE_DW-1:0]   rbuf_nxt;

    logic [RATIO-1:0]     nb_mask;
    logic [WIDE_AW-1:0]   nb_base;
    logic [WIDE_DW-1:0]   nb_wide;
    logic [WSW-1:0]       nb_wsel;
    logic [LGR-1:0]       nb_lane;
    logic [NAW-1:0]       nb_addr;
    logic [NARROW_DW-1:0] nb_wdata;
    logic [NSW-1:0]       nb_sel;

    // A lane is active when any of its byte selects is set.
    always_comb begin
        lanes_in = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            lanes_in[i] = |s_sel_i[i*NSW +: NSW];
        end
    end

    // Beat retirement and read-data capture; acks are only honoured inside a narrow cycle.
    always_comb begin
        stb_acc   = m_stb_q && !m_stall_i;
        err_v     = m_cyc_q && m_err_i;
        ack_v     = m_cyc_q && m_ack_i && !m_err_i;
        ret_lane  = low_lane(ret_q);
        issue_nxt = issue_q;
        ret_nxt   = ret_q;
        rbuf_nxt  = rbuf_q;
        if (stb_acc) begin
            issue_nxt = issue_q & ~onehot(low_lane(issue_q));
        end
        if (ack_v) begin
            ret_nxt = ret_q & ~onehot(ret_lane);
            for (int i = 0; i < int'(RATIO); i++) begin
                if (ret_lane == LGR'(i)) rbuf_nxt[i*NARROW_DW +: NARROW_DW] = m_rdata_i;
            end
        end
    end

    // Next narrow beat: from the incoming request when idle, else from the remaining issue mask.
    always_comb begin
        if (state_q == IDLE) begin
            nb_mask = lanes_in;
            nb_base = s_addr_i;
            nb_wide = s_wdata_i;
            nb_wsel = s_sel_i;
        end else begin
            nb_mask = issue_nxt;
            nb_base = addr_q;
            nb_wide = wdata_q;
            nb_wsel = sel_q;
        end
        nb_lane  = low_lane(nb_mask);
        nb_addr  = {nb_base, nb_lane};
        nb_wdata = '0;
        nb_sel   = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (nb_lane == LGR'(i)) begin
                nb_wdata = nb_wide[i*NARROW_DW +: NARROW_DW];
                nb_sel   = nb_wsel[i*NSW +: NSW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        we_d      = we_q;
        issue_d   = issue_q;
        ret_d     = ret_q;
        rbuf_d    = rbuf_q;
        s_ack_d   = 1'b0;
        s_err_d   = 1'b0;
        s_rdata_d = s_rdata_q;
        m_cyc_d   = m_cyc_q;
        m_stb_d   = m_stb_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_sel_d   = m_sel_q;

        case (state_q)
            IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    addr_d  = s_addr_i;
                    wdata_d = s_wdata_i;
                    sel_d   = s_sel_i;
                    we_d    = s_we_i;
                    issue_d = lanes_in;
                    ret_d   = lanes_in;
                    rbuf_d  = '0;
                    if (lanes_in == '0) begin
                        state_d   = RESP;
                        s_ack_d   = 1'b1;
                        s_rdata_d = '0;
                    end else begin
                        state_d   = ISSUE;
                        m_cyc_d   = 1'b1;
                        m_stb_d   = 1'b1;
                        m_we_d    = s_we_i;
                        m_addr_d  = nb_addr;
                        m_wdata_d = nb_wdata;
                        m_sel_d   = nb_sel;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (!s_cyc_i) begin
                    // Initiator abandoned the cycle: quiesce without a response.
                    state_d = IDLE;
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                end else if (err_v) begin
                    state_d   = RESP;
                    s_err_d   = 1'b1;
                    s_rdata_d = rbuf_q;
                    m_cyc_d   = 1'b0;
                    m_stb_d   = 1'b0;
                end else begin
                    issue_d = issue_nxt;
                    ret_d   = ret_nxt;
                    rbuf_d  = rbuf_nxt;
                    if (issue_nxt != '0) begin
                        if (stb_acc) begin
                            m_addr_d  = nb_addr;
                            m_wdata_d = nb_wdata;
                            m_sel_d   = nb_sel;
                        end
                    end else begin
                        m_stb_d = 1'b0;
                        if (ret_nxt == '0) begin
                            state_d   = RESP;
                            s_ack_d   = 1'b1;
                            s_rdata_d = rbuf_nxt;
                            m_cyc_d   = 1'b0;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_stall_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            issue_q   <= '0;
            ret_q     <= '0;
            rbuf_q    <= '0;
            s_stall_q <= 1'b0;
            s_ack_q   <= 1'b0;
            s_err_q   <= 1'b0;
            s_rdata_q <= '0;
            m_cyc_q   <= 1'b0;
            m_stb_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_sel_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            issue_q   <= issue_d;
            ret_q     <= ret_d;
            rbuf_q    <= rbuf_d;
            s_stall_q <= s_stall_d;
            s_ack_q   <= s_ack_d;
            s_err_q   <= s_err_d;
            s_rdata_q <= s_rdata_d;
            m_cyc_q   <= m_cyc_d;
            m_stb_q   <= m_stb_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_sel_q   <= m_sel_d;
        end
    end

    assign s_stall_o = s_stall_q;
    assign s_ack_o   = s_ack_q;
    assign s_err_o   = s_err_q;
    assign s_rdata_o = s_rdata_q;
    assign m_cyc_o   = m_cyc_q;
    assign m_stb_o   = m_stb_q;
    assign m_we_o    = m_we_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;
    assign m_sel_o   = m_sel_q;

endmodule

// File: tb/tb_sec_wb_dnsz.sv
// Directed bench for sec_wb_dnsz with a zero-wait narrow slave that can stall and inject an error.
module tb_sec_wb_dnsz;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          s_cyc_i, s_stb_i, s_we_i;
    logic [25:0]   s_addr_i;
    logic [127:0]  s_wdata_i;
    logic [15:0]   s_sel_i;
    logic          s_stall_o, s_ack_o, s_err_o;
    logic [127:0]  s_rdata_o;
    logic          m_cyc_o, m_stb_o, m_we_o;
    logic [27:0]   m_addr_o;
    logic [31:0]   m_wdata_o;
    logic [3:0]    m_sel_o;
    logic          m_stall_i, m_ack_i, m_err_i;
    logic [31:0]   m_rdata_i;

    always #5 clk_i = ~clk_i;

    sec_wb_dnsz dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .s_cyc_i   (s_cyc_i),
        .s_stb_i   (s_stb_i),
        .s_we_i    (s_we_i),
        .s_addr_i  (s_addr_i),
        .s_wdata_i (s_wdata_i),
        .s_sel_i   (s_sel_i),
        .s_stall_o (s_stall_o),
        .s_ack_o   (s_ack_o),
        .s_err_o   (s_err_o),
        .s_rdata_o (s_rdata_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_sel_o   (m_sel_o),
        .m_stall_i (m_stall_i),
        .m_ack_i   (m_ack_i),
        .m_err_i   (m_err_i),
        .m_rdata_i (m_rdata_i)
    );

    int n_chk, n_pass, n_fail;

    logic [31:0] mem [4];
    int          stall_cnt;
    int          err_on_ack;
    int          ack_idx;
    int          beats;
    logic [27:0] b_addr [$];
    logic [31:0] b_wdata [$];
    logic [3:0]  b_sel [$];
    logic        b_we [$];
    logic [27:0] st_addr [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_slave();
        beats   = 0;
        ack_idx = 0;
        b_addr.delete();
        b_wdata.delete();
        b_sel.delete();
        b_we.delete();
        st_addr.delete();
    endtask

    // Narrow slave: acks each accepted beat one cycle later with mem[lane].
    initial begin : slave
        logic       acc;
        logic [1:0] lane;
        acc = 1'b0;
        lane = 2'd0;
        m_stall_i = 1'b0;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_rdata_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            m_ack_i = 1'b0;
            m_err_i = 1'b0;
            if (acc) begin
                ack_idx++;
                if (ack_idx == err_on_ack) m_err_i = 1'b1;
                else begin
                    m_ack_i = 1'b1;
                    m_rdata_i = mem[lane];
                end
            end
            if (stall_cnt > 0 && m_stb_o) begin
                m_stall_i = 1'b1;
                stall_cnt--;
            end else begin
                m_stall_i = 1'b0;
            end
            @(negedge clk_i);
            acc = m_cyc_o && m_stb_o && !m_stall_i;
            if (acc) begin
                lane = m_addr_o[1:0];
                beats++;
                b_addr.push_back(m_addr_o);
                b_wdata.push_back(m_wdata_o);
                b_sel.push_back(m_sel_o);
                b_we.push_back(m_we_o);
            end
            if (m_stb_o && m_stall_i) st_addr.push_back(m_addr_o);
        end
    end

    // Issue one wide request at cycle 0 and observe 20 cycles; abort_at>0 drops s_cyc_i in that cycle.
    task automatic run_req(input logic we, input logic [25:0] addr, input logic [127:0] wd,
                           input logic [15:0] sel, input int abort_at,
                           output int resp_cyc, output int n_ack, output int n_err,
                           output logic [127:0] rd, output logic cyc_at_resp,
                           output logic cyc_after_abort);
        resp_cyc = -1;
        n_ack = 0;
        n_err = 0;
        rd = '0;
        cyc_at_resp = 1'b1;
        cyc_after_abort = 1'b1;
        clear_slave();
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_we_i = we;
        s_addr_i = addr;
        s_wdata_i = wd;
        s_sel_i = sel;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_i);
            #2;
            if (k == 1) s_stb_i = 1'b0;
            if (abort_at != 0 && k == abort_at) s_cyc_i = 1'b0;
            if (abort_at != 0 && k == abort_at + 1) cyc_after_abort = m_cyc_o;
            if (s_ack_o || s_err_o) begin
                if (resp_cyc < 0) begin
                    resp_cyc = k;
                    rd = s_rdata_o;
                    cyc_at_resp = m_cyc_o;
                end
                if (s_ack_o) n_ack++;
                if (s_err_o) n_err++;
                s_cyc_i = 1'b0;
            end
        end
    endtask

    initial begin : main
        int           rc, na, ne;
        logic [127:0] rd;
        logic         cr, ca;
        n_chk = 0;
        n_pass = 0;
        n_fail = 0;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        mem[3] = 32'h44444444;
        stall_cnt = 0;
        err_on_ack = 0;
        clear_slave();
        rstn_i = 1'b0;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i = 1'b0;
        s_addr_i = '0;
        s_wdata_i = '0;
        s_sel_i = '0;
        repeat (3) @(posedge clk_i);
        #2;
        check("reset_ctrl", {s_stall_o, s_ack_o, s_err_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_wdata_o}, '0);
        check("reset_addr", m_addr_o, '0);
        check("reset_rdata", s_rdata_o, '0);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #2;

        // Full 4-lane read
        run_req(1'b0, 26'h100, '0, 16'hFFFF, 0, rc, na, ne, rd, cr, ca);
        check("rd_ack_cycle", 128'(rc), 128'd6);
        check("rd_n_ack", 128'(na), 128'd1);
        check("rd_n_err", 128'(ne), 128'd0);
        check("rd_data", rd, 128'h44444444_33333333_22222222_11111111);
        check("rd_beats", 128'(beats), 128'd4);
        check("rd_addr0", 128'(b_addr[0]), 128'h400);
        check("rd_addr3", 128'(b_addr[3]), 128'h403);
        check("rd_cyc_low_at_ack", 128'(cr), 128'd0);

        // Single-lane write
        run_req(1'b1, 26'h10, 128'h00000000_00000000_DEADBEEF_00000000, 16'h00F0, 0, rc, na, ne, rd, cr, ca);
        check("wr_ack_cycle", 128'(rc), 128'd3);
        check("wr_n_ack", 128'(na), 128'd1);
        check("wr_beats", 128'(beats), 128'd1);
        check("wr_addr", 128'(b_addr[0]), 128'h41);
        check("wr_sel", 128'(b_sel[0]), 128'hF);
        check("wr_wdata", 128'(b_wdata[0]), 128'hDEADBEEF);
        check("wr_we", 128'(b_we[0]), 128'd1);

        // Zero byte selects: immediate ack, no narrow traffic
        run_req(1'b0, 26'h55, '0, 16'h0000, 0, rc, na, ne, rd, cr, ca);
        check("zs_ack_cycle", 128'(rc), 128'd1);
        check("zs_n_ack", 128'(na), 128'd1);
        check("zs_rdata", rd, '0);
        check("zs_beats", 128'(beats), 128'd0);

        // Sparse lanes with the first beat stalled for 3 cycles
        stall_cnt = 3;
        run_req(1'b0, 26'h20, '0, 16'hF0F0, 0, rc, na, ne, rd, cr, ca);
        check("bp_ack_cycle", 128'(rc), 128'd7);
        check("bp_data", rd, 128'h44444444_00000000_22222222_00000000);
        check("bp_addr0", 128'(b_addr[0]), 128'h81);
        check("bp_addr1", 128'(b_addr[1]), 128'h83);
        check("bp_stall_cycles", 128'(st_addr.size()), 128'd3);
        for (int i = 0; i < st_addr.size(); i++) check("bp_stall_addr", 128'(st_addr[i]), 128'h81);

        // Error on the second narrow response
        err_on_ack = 2;
        run_req(1'b0, 26'h0, '0, 16'hFFFF, 0, rc, na, ne, rd, cr, ca);
        err_on_ack = 0;
        check("er_n_err", 128'(ne), 128'd1);
        check("er_n_ack", 128'(na), 128'd0);
        check("er_cycle", 128'(rc), 128'd4);
        check("er_cyc_low", 128'(cr), 128'd0);
        check("er_beats", 128'(beats), 128'd3);

        // Abort in cycle 3, then a normal request
        run_req(1'b0, 26'h300, '0, 16'hFFFF, 3, rc, na, ne, rd, cr, ca);
        check("ab_n_ack", 128'(na), 128'd0);
        check("ab_n_err", 128'(ne), 128'd0);
        check("ab_cyc_low", 128'(ca), 128'd0);
        check("ab_beats", 128'(beats), 128'd3);
        run_req(1'b0, 26'h100, '0, 16'hFFFF, 0, rc, na, ne, rd, cr, ca);
        check("ab_next_ack_cycle", 128'(rc), 128'd6);
        check("ab_next_data", rd, 128'h44444444_33333333_22222222_11111111);

        // Asynchronous reset in the middle of issuing
        clear_slave();
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_we_i = 1'b0;
        s_addr_i = 26'h100;
        s_sel_i = 16'hFFFF;
        @(posedge clk_i);
        #2;
        s_stb_i = 1'b0;
        @(posedge clk_i);
        #2;
        check("rs_mid_stb", 128'(m_stb_o), 128'd1);
        check("rs_mid_addr", 128'(m_addr_o), 128'h401);
        #2;
        rstn_i = 1'b0;
        #1;
        check("rs_ctrl", {s_stall_o, s_ack_o, s_err_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_wdata_o}, '0);
        check("rs_addr", m_addr_o, '0);
        check("rs_rdata", s_rdata_o, '0);
        s_cyc_i = 1'b0;
        @(posedge clk_i);
        #2;
        rstn_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sec_wb_dnsz.md
Name: sec_wb_dnsz

Overview:
Wishbone pipelined bus-width downsizer for the secondary bus. It presents a 128-bit responder port toward the secondary crossbar's slave side and issues up to four 32-bit initiator beats toward a narrow peripheral or memory controller. Each accepted wide request is split into one narrow beat per active 32-bit lane. Narrow read data is reassembled into a single wide response. Lanes are little-endian: lane 0 is wide bits 31:0.

Parameters:
WIDE_AW, 26, wide word-address width (matches secondary bus AW)
WIDE_DW, 128, wide data width
NARROW_DW, 32, narrow data width; RATIO = WIDE_DW/NARROW_DW = 4, LGR = 2

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
s_cyc_i, s_stb_i, s_we_i  in  1 each  wide responder cycle/strobe/write-enable
s_addr_i  in  WIDE_AW  wide word address
s_wdata_i  in  WIDE_DW  write data
s_sel_i  in  WIDE_DW/8  byte selects
s_stall_o, s_ack_o, s_err_o  out  1 each  stall/ack/error to wide initiator
s_rdata_o  out  WIDE_DW  read data
m_cyc_o, m_stb_o, m_we_o  out  1 each  narrow initiator cycle/strobe/write-enable
m_addr_o  out  WIDE_AW+LGR  narrow word address
m_wdata_o  out  NARROW_DW  narrow write data
m_sel_o  out  NARROW_DW/8  narrow byte selects
m_stall_i, m_ack_i, m_err_i  in  1 each  narrow slave stall/ack/error
m_rdata_i  in  NARROW_DW  narrow read data

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE. All outputs 0, including s_rdata_o and m_addr_o.
- Exactly one wide transaction in flight. s_stall_o = (state != IDLE).
- Accept: IDLE & s_cyc_i & s_stb_i. Latch addr, wdata, sel, we. Compute lane mask L[i] = |s_sel_i[4i+3:4i]. Clear the read buffer to 0.
- L == 0: go to RESP. s_ack_o asserts the next cycle; no narrow traffic; rdata = 0.
- States:
  - IDLE.
  - ISSUE: beats are outstanding or not yet issued.
  - WAIT: all beats issued, acks pending.
  - RESP: one-cycle response.
- ISSUE: m_cyc_o=1, m_stb_o=1. Beat lane = lowest set bit of the issue mask. m_addr_o = {addr, lane}, m_wdata_o = wdata lane, m_sel_o = sel nibble, m_we_o = we. Beat is accepted when !m_stall_i; clear that lane bit in the issue mask. Beats are issued back-to-back, in ascending lane order, with unused lanes skipped. When the last beat is accepted, go to WAIT, or go directly to RESP if all acks are already in.
- Ack mapping: separate return mask initialised to L. Each m_ack_i writes m_rdata_i into the lowest set lane of the return mask and clears that bit. An ack in the same cycle as stb acceptance is legal.
- m_cyc_o stays high from the first beat until the cycle the final ack or err arrives; it drops the following cycle.
- RESP: s_ack_o (or s_err_o) is high for exactly one cycle. s_rdata_o is valid only in that cycle and is held otherwise; value is don't-care to the initiator. Next state is IDLE.
- Latency, zero-wait narrow slave (ack 1 cycle after stb), 4-lane read accepted at cycle 0: stb at cycles 1–4, acks at 2–5, s_ack_o at cycle 6.
- m_err_i in ISSUE/WAIT: stop issuing and drop m_cyc_o the next cycle. Ignore further m_ack_i. Go to RESP with s_err_o=1, s_ack_o=0.
- s_cyc_i dropped while state != IDLE: abort. Next cycle m_cyc_o=m_stb_o=0, state=IDLE. No s_ack_o or s_err_o is generated.
- Simultaneous m_ack_i and m_err_i: err wins.
- An ack arriving while m_cyc_o=0 is ignored.
- Reset mid-transaction: all outputs return to 0 immediately (async).

Test Plan:
- Full read: sel=0xFFFF, addr=0x0000100, slave returns 0x11111111,0x22222222,0x33333333,0x44444444 → narrow addrs 0x400..0x403. s_rdata_o=0x44444444_33333333_22222222_11111111; s_ack_o at cycle 6; one ack only.
- Partial write: sel=0x00F0, wdata lane1=0xDEADBEEF, addr=0x10 → exactly one narrow beat, m_addr_o=0x41, m_sel_o=0xF, m_wdata_o=0xDEADBEEF, m_we_o=1 → one s_ack_o.
- Zero select: sel=0x0000 read → no m_cyc_o; s_ack_o at cycle 1, rdata=0.
- Backpressure: sel=0xF0F0 read, m_stall_i high for 3 cycles on the first beat → beats at lanes 1 then 3. Addr/data held stable while stalled. rdata lanes 1,3 filled, lanes 0,2 = 0.
- Error: 4-lane read, m_err_i on 2nd ack → s_err_o=1 for one cycle, no s_ack_o. m_cyc_o low the next cycle; no further stb.
- Abort and reset: s_cyc_i drops after 2 beats → m_cyc_o low next cycle, no response. A new request is accepted afterward and completes normally. rstn_i low mid-ISSUE → all outputs 0 asynchronously.
